// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between instruction fetch and load/store.
// Round-robin on conflict, one outstanding transaction, RISC-V lane handling.
module mem_port_arbiter #(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [Width-1:0] if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [Width-1:0] if_rdata,
    input  logic             ls_req,
    input  logic             ls_we,
    input  logic [2:0]       ls_op,
    input  logic [Width-1:0] ls_addr,
    input  logic [Width-1:0] ls_wdata,
    output logic             ls_gnt,
    output logic             ls_rvalid,
    output logic [Width-1:0] ls_rdata,
    output logic             ls_err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [Width-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [Width-1:0] mem_wdata,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [Width-1:0] mem_rdata,
    output logic [1:0]       dbg_state
);

    // Handshake: a requester holds req until its gnt pulse; gnt, rvalid and
    // the request fields are only meaningful in the cycle they are high.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             last_ls_q, last_ls_d;
    logic             owner_ls_q, owner_ls_d;
    logic             we_q, we_d;
    logic [2:0]       op_q, op_d;
    logic [Width-1:0] addr_q, addr_d;
    logic [Width-1:0] wdata_q, wdata_d;
    logic             if_rvalid_q, if_rvalid_d;
    logic [Width-1:0] if_rdata_q, if_rdata_d;
    logic             ls_rvalid_q, ls_rvalid_d;
    logic [Width-1:0] ls_rdata_q, ls_rdata_d;
    logic             ls_err_q, ls_err_d;

    logic             pick_ls, pick_if, idle_grant;
    logic             ls_misaligned, ls_bad_op, ls_bad;
    logic             in_req;
    logic [3:0]       be_lat;
    logic [Width-1:0] wdata_lat;
    logic [Width-1:0] rd_shift, load_ext;

    // Fetch wins a conflict only when load/store was granted last.
    assign pick_ls    = ls_req && (!if_req || !last_ls_q);
    assign pick_if    = if_req && !pick_ls;
    assign idle_grant = rst && (state_q == ST_IDLE);
    assign if_gnt     = idle_grant && pick_if;
    assign ls_gnt     = idle_grant && pick_ls;

    always_comb begin
        ls_misaligned = 1'b0;
        case (ls_op[1:0])
            2'd1:    ls_misaligned = ls_addr[0];
            2'd2:    ls_misaligned = |ls_addr[1:0];
            default: ls_misaligned = 1'b0;
        endcase
        ls_bad_op = ls_we ? (ls_op > 3'd2)
                          : ((ls_op[1:0] == 2'd3) || (ls_op[2:1] == 2'b11));
        ls_bad    = ls_bad_op || ls_misaligned;
    end

    always_comb begin
        be_lat    = 4'b1111;
        wdata_lat = wdata_q;
        if (owner_ls_q) begin
            case (op_q[1:0])
                2'd0: begin
                    be_lat    = 4'b0001 << addr_q[1:0];
                    wdata_lat = {(Width/8){wdata_q[7:0]}};
                end
                2'd1: begin
                    be_lat    = addr_q[1] ? 4'b1100 : 4'b0011;
                    wdata_lat = {(Width/16){wdata_q[15:0]}};
                end
                default: begin
                    be_lat    = 4'b1111;
                    wdata_lat = wdata_q;
                end
            endcase
        end
    end

    always_comb begin
        rd_shift = mem_rdata >> {addr_q[1:0], 3'b000};
        case (op_q)
            3'd0:    load_ext = {{(Width-8){rd_shift[7]}}, rd_shift[7:0]};
            3'd1:    load_ext = {{(Width-16){rd_shift[15]}}, rd_shift[15:0]};
            3'd4:    load_ext = {{(Width-8){1'b0}}, rd_shift[7:0]};
            3'd5:    load_ext = {{(Width-16){1'b0}}, rd_shift[15:0]};
            default: load_ext = rd_shift;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        last_ls_d   = last_ls_q;
        owner_ls_d  = owner_ls_q;
        we_d        = we_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = '0;
        ls_rvalid_d = 1'b0;
        ls_rdata_d  = '0;
        ls_err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_ls || pick_if) begin
                    last_ls_d = pick_ls;
                    // A rejected load/store never reaches memory; it answers next cycle.
                    if (pick_ls && ls_bad) begin
                        ls_rvalid_d = 1'b1;
                        ls_err_d    = 1'b1;
                    end else begin
                        state_d    = ST_REQ;
                        owner_ls_d = pick_ls;
                        we_d       = pick_ls && ls_we;
                        op_d       = pick_ls ? ls_op : 3'd2;
                        addr_d     = pick_ls ? ls_addr : if_addr;
                        wdata_d    = pick_ls ? ls_wdata : '0;
                    end
                end
            end
            ST_REQ: begin
                if (mem_gnt) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (mem_rvalid) begin
                    state_d = ST_IDLE;
                    if (owner_ls_q) begin
                        ls_rvalid_d = 1'b1;
                        ls_rdata_d  = we_q ? '0 : load_ext;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            last_ls_q   <= 1'b0;
            owner_ls_q  <= 1'b0;
            we_q        <= 1'b0;
            op_q        <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rvalid_q <= 1'b0;
            ls_rdata_q  <= '0;
            ls_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_ls_q   <= last_ls_d;
            owner_ls_q  <= owner_ls_d;
            we_q        <= we_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rvalid_q <= ls_rvalid_d;
            ls_rdata_q  <= ls_rdata_d;
            ls_err_q    <= ls_err_d;
        end
    end

    // Memory-side fields are zero outside REQ so the port is quiet when idle.
    assign in_req    = (state_q == ST_REQ);
    assign mem_req   = in_req;
    assign mem_we    = in_req && we_q;
    assign mem_addr  = in_req ? {addr_q[Width-1:2], 2'b00} : '0;
    assign mem_be    = in_req ? be_lat : 4'b0000;
    assign mem_wdata = (in_req && we_q) ? wdata_lat : '0;

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rvalid = ls_rvalid_q;
    assign ls_rdata  = ls_rdata_q;
    assign ls_err    = ls_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a behavioural
// model of arbitration order, lane handling and response timing.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [2:0]  ls_op;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_gnt, ls_rvalid, ls_err;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    // Scoreboard entry: {owner_is_ls, err, rdata}
    logic [33:0] exp_q[$];
    bit          exp_due = 1'b0;
    bit          last_ls = 1'b0;

    mem_port_arbiter #(.Width(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_op(ls_op), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
        .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [2:0] op);
        case (op % 4)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit ls_illegal(input bit we, input logic [2:0] op, input logic [31:0] addr);
        bit legal_op;
        legal_op = we ? (op <= 3'd2) : (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal_op) return 1'b1;
        return (addr % size_bytes(op)) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] op, input logic [31:0] addr);
        int n, a;
        n = size_bytes(op);
        a = int'(addr % 4);
        return 4'(((1 << n) - 1) << a);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] op, input logic [31:0] wd);
        logic [31:0] b, h;
        b = wd & 32'hFF;
        h = wd & 32'hFFFF;
        case (size_bytes(op))
            1:       return b * 32'h0101_0101;
            2:       return h * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
        longint v, span;
        int n;
        n = size_bytes(op);
        v = longint'(rd >> (8 * (addr % 4)));
        if (n < 4) begin
            span = longint'(1) << (8 * n);
            v = v % span;
            if (op < 3'd4 && v >= span / 2) v = v - span;
        end
        return 32'(v);
    endfunction

    // ---------------- per-cycle response check ----------------
    task automatic resp_check();
        logic [33:0] e;
        check_eq("gnt_exclusive", {31'b0, if_gnt & ls_gnt}, 32'h0);
        if (exp_due) begin
            e = exp_q.pop_front();
            exp_due = 1'b0;
            check_eq("if_rvalid", {31'b0, if_rvalid}, {31'b0, !e[33]});
            check_eq("ls_rvalid", {31'b0, ls_rvalid}, {31'b0, e[33]});
            if (e[33]) begin
                check_eq("ls_err", {31'b0, ls_err}, {31'b0, e[32]});
                check_eq("ls_rdata", ls_rdata, e[31:0]);
            end else begin
                check_eq("if_rdata", if_rdata, e[31:0]);
            end
        end else begin
            check_eq("no_rvalid", {29'b0, if_rvalid, ls_rvalid, ls_err}, 32'h0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctl"}, {25'b0, if_gnt, if_rvalid, ls_gnt, ls_rvalid, ls_err, mem_req, mem_we}, 32'h0);
        check_eq({tag, "_if_rdata"}, if_rdata, 32'h0);
        check_eq({tag, "_ls_rdata"}, ls_rdata, 32'h0);
        check_eq({tag, "_mem_addr"}, mem_addr, 32'h0);
        check_eq({tag, "_mem_be"}, {28'b0, mem_be}, 32'h0);
        check_eq({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic run_txn(input bit want_if, input bit want_ls, input logic [31:0] i_addr,
                           input bit l_we, input logic [2:0] l_op, input logic [31:0] l_addr,
                           input logic [31:0] l_wdata, input int gw, input int rw,
                           input logic [31:0] rdata);
        bit win_ls;
        logic [31:0] waddr, own_addr;
        @(negedge clk);
        rst = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if_req = want_if; if_addr = i_addr;
        ls_req = want_ls; ls_we = l_we; ls_op = l_op; ls_addr = l_addr; ls_wdata = l_wdata;
        #1;
        resp_check();
        check_eq("idle_mem_req", {31'b0, mem_req}, 32'h0);
        win_ls = want_ls && (!want_if || !last_ls);
        check_eq("if_gnt", {31'b0, if_gnt}, {31'b0, want_if && !win_ls});
        check_eq("ls_gnt", {31'b0, ls_gnt}, {31'b0, win_ls});
        last_ls = win_ls;
        if (win_ls && ls_illegal(l_we, l_op, l_addr)) begin
            exp_q.push_back({1'b1, 1'b1, 32'h0});
            exp_due = 1'b1;
            return;
        end
        own_addr = win_ls ? l_addr : i_addr;
        waddr = own_addr - (own_addr % 4);
        @(negedge clk);
        if (win_ls) ls_req = 1'b0; else if_req = 1'b0;
        #1;
        resp_check();
        check_eq("mem_req", {31'b0, mem_req}, 32'h1);
        check_eq("mem_addr", mem_addr, waddr);
        check_eq("mem_we", {31'b0, mem_we}, {31'b0, win_ls && l_we});
        check_eq("mem_be", {28'b0, mem_be}, {28'b0, win_ls ? exp_be(l_op, l_addr) : 4'hF});
        if (win_ls && l_we) check_eq("mem_wdata", mem_wdata, exp_wdata(l_op, l_wdata));
        mem_gnt = (gw == 0);
        mem_rvalid = 1'($urandom_range(0, 1));
        for (int i = 1; i <= gw; i++) begin
            @(negedge clk);
            #1;
            resp_check();
            check_eq("stall_mem_req", {31'b0, mem_req}, 32'h1);
            check_eq("stall_mem_addr", mem_addr, waddr);
            mem_gnt = (i == gw);
            mem_rvalid = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i <= rw; i++) begin
            @(negedge clk);
            mem_gnt = 1'b0;
            #1;
            resp_check();
            check_eq("resp_mem_req", {31'b0, mem_req}, 32'h0);
            mem_rvalid = (i == rw);
            mem_rdata = (i == rw) ? rdata : $urandom;
        end
        if (!win_ls) exp_q.push_back({2'b00, rdata});
        else if (l_we) exp_q.push_back({2'b10, 32'h0});
        else exp_q.push_back({2'b10, exp_load(l_op, l_addr, rdata)});
        exp_due = 1'b1;
    endtask

    task automatic flush();
        @(negedge clk);
        rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        resp_check();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; if_req = 1'b0; ls_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        exp_q.delete(); exp_due = 1'b0; last_ls = 1'b0;
        @(negedge clk);
        #1;
        check_all_zero("reset_again");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit          wi, wl, we;
        int          sel;
        logic [2:0]  op;
        logic [31:0] la, ia;
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h40;
        ls_req = 1'b0; ls_we = 1'b0; ls_op = 3'd0; ls_addr = 32'h0; ls_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");

        run_txn(1, 0, 32'h40, 0, 3'd0, 32'h0, 32'h0, 0, 0, $urandom);
        run_txn(0, 1, 32'h0, 0, 3'd0, 32'h103, 32'h0, 0, 1, 32'h80FF_1234);
        run_txn(0, 1, 32'h0, 0, 3'd4, 32'h103, 32'h0, 1, 0, 32'h80FF_1234);
        run_txn(0, 1, 32'h0, 1, 3'd1, 32'h202, 32'hDEAD_BEEF, 2, 1, $urandom);
        run_txn(0, 1, 32'h0, 0, 3'd2, 32'h6, 32'h0, 0, 0, 32'h0);
        run_txn(0, 1, 32'h0, 0, 3'd1, 32'h2, 32'h0, 0, 0, 32'h8001_0000);
        run_txn(0, 1, 32'h0, 0, 3'd7, 32'h10, 32'h0, 0, 0, 32'h0);
        run_txn(0, 1, 32'h0, 1, 3'd0, 32'h11, 32'h1234_56A5, 0, 2, $urandom);
        flush();
        do_reset();

        for (int k = 0; k < 4; k++)
            run_txn(1, 1, 32'h1000 + 32'(4 * k), 0, 3'd2, 32'h2000, 32'h0, 0, 0, $urandom);

        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 2);
            wi  = (sel != 1);
            wl  = (sel != 0);
            we  = 1'($urandom_range(0, 1));
            op  = 3'($urandom_range(0, 7));
            la  = $urandom;
            if ($urandom_range(0, 1) == 1) la[1:0] = 2'b00;
            ia  = $urandom & 32'hFFFF_FFFC;
            run_txn(wi, wl, ia, we, op, la, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end
        flush();

        @(negedge clk);
        rst = 1'b1; if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b0; ls_op = 3'd2;
        ls_addr = 32'h300; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        resp_check();
        check_eq("bp_ls_gnt", {31'b0, ls_gnt}, 32'h1);
        @(negedge clk);
        ls_req = 1'b0;
        #1;
        resp_check();
        check_eq("bp_mem_req", {31'b0, mem_req}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            resp_check();
            check_eq("bp_stall_req", {31'b0, mem_req}, 32'h1);
            check_eq("bp_stall_addr", mem_addr, 32'h300);
            check_eq("bp_stall_be", {28'b0, mem_be}, 32'hF);
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        resp_check();
        check_eq("bp_resp_req", {31'b0, mem_req}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_all_zero("reset_mid");
        exp_q.delete(); exp_due = 1'b0; last_ls = 1'b0;
        rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        resp_check();
        check_eq("late_rvalid_mem_req", {31'b0, mem_req}, 32'h0);
        flush();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
